// File: rtl/irq_ctrl.sv
// ============================================================================
// irq_ctrl : priority interrupt controller, edge capture + CPU req/ack/EOI
// Rev 1.0
// ============================================================================
`default_nettype none

module irq_ctrl #(
   parameter int          NUM_IRQ   = 8,
   parameter logic [15:0] BASE_ADDR = 16'h1000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_IRQ-1:0] irq_in,
   input  logic [15:0]        io_addr,
   input  logic [7:0]         io_wdata,
   input  logic               io_we,
   input  logic               io_re,
   output logic [7:0]         io_rdata,
   output logic               cpu_irq,
   output logic [2:0]         cpu_vector,
   input  logic               cpu_ack
);

   localparam logic [1:0] c_IDLE    = 2'd0;
   localparam logic [1:0] c_REQ     = 2'd1;
   localparam logic [1:0] c_SERVICE = 2'd2;

   logic [1:0]         state_q, state_d;
   logic [NUM_IRQ-1:0] prev_q;
   logic [NUM_IRQ-1:0] mask_q, mask_d;
   logic [NUM_IRQ-1:0] pending_q, pending_d;
   logic               irq_q, irq_d;
   logic [2:0]         vector_q, vector_d;
   logic [7:0]         rdata_q, rdata_d;

   logic [15:0]        offset;
   logic               in_range;
   logic               wr_mask, wr_pend, wr_eoi, rd_en;
   logic [NUM_IRQ-1:0] rise, clr, vec_onehot, eligible;
   logic               any_eligible, latched_live, in_svc;
   logic [2:0]         sel;
   logic [7:0]         rd_mux;

   // Unsigned wrap makes addresses below BASE_ADDR fall out of range too
   assign offset   = io_addr - BASE_ADDR;
   assign in_range = (offset[15:2] == 14'd0);
   assign wr_mask  = io_we & in_range & (offset[1:0] == 2'd0);
   assign wr_pend  = io_we & in_range & (offset[1:0] == 2'd1);
   assign wr_eoi   = io_we & in_range & (offset[1:0] == 2'd3);
   assign rd_en    = io_re & in_range;

   assign eligible     = pending_q & mask_q;
   assign any_eligible = |eligible;

   always_comb begin
      vec_onehot = '0;
      sel        = 3'd0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         vec_onehot[i] = (vector_q == 3'(i));
         if (eligible[i]) sel = 3'(i);
      end
   end

   assign latched_live = |(eligible & vec_onehot);

   // Set beats clear: rise is OR-ed in after the clear mask is applied
   always_comb begin
      rise      = irq_in & ~prev_q;
      clr       = wr_pend ? io_wdata[NUM_IRQ-1:0] : '0;
      if ((state_q == c_REQ) && cpu_ack) clr = clr | vec_onehot;
      pending_d = (pending_q & ~clr) | rise;
      mask_d    = wr_mask ? io_wdata[NUM_IRQ-1:0] : mask_q;
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= c_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         c_IDLE:    if (any_eligible) state_d = c_REQ;
         c_REQ: begin
            if (cpu_ack)            state_d = c_SERVICE;
            else if (!latched_live) state_d = c_IDLE;
         end
         c_SERVICE: if (wr_eoi) state_d = c_IDLE;
         default:   state_d = c_IDLE;
      endcase
   end

   always_comb begin
      irq_d    = (state_d == c_REQ);
      vector_d = ((state_q == c_IDLE) && any_eligible) ? sel : vector_q;
      in_svc   = (state_q == c_SERVICE);
      case (offset[1:0])
         2'd0:    rd_mux = 8'(mask_q);
         2'd1:    rd_mux = 8'(pending_q);
         2'd2:    rd_mux = {in_svc, 4'b0000, (in_svc ? vector_q : 3'd0)};
         default: rd_mux = 8'h00;
      endcase
      rdata_d = rd_en ? rd_mux : rdata_q;
   end

   // prev_q tracks irq_in during reset so levels held across reset are not edges
   always_ff @(posedge clk) begin
      prev_q <= irq_in;
      if (rst) begin
         mask_q    <= '0;
         pending_q <= '0;
         irq_q     <= 1'b0;
         vector_q  <= 3'd0;
         rdata_q   <= 8'h00;
      end else begin
         mask_q    <= mask_d;
         pending_q <= pending_d;
         irq_q     <= irq_d;
         vector_q  <= vector_d;
         rdata_q   <= rdata_d;
      end
   end

   assign io_rdata   = rdata_q;
   assign cpu_irq    = irq_q;
   assign cpu_vector = vector_q;

endmodule

`default_nettype wire

// File: tb/tb_irq_ctrl.sv
// ============================================================================
// tb_irq_ctrl : directed self-checking bench for irq_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_irq_ctrl;

   localparam logic [15:0] BASE = 16'h1000;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] irq_in;
   logic [15:0] io_addr;
   logic [7:0] io_wdata;
   logic       io_we, io_re;
   logic [7:0] io_rdata;
   logic       cpu_irq;
   logic [2:0] cpu_vector;
   logic       cpu_ack;

   int n_cmp = 0;
   int n_err = 0;
   logic [7:0] rv;

   irq_ctrl #(.NUM_IRQ(8), .BASE_ADDR(BASE)) dut (
      .clk       (clk),
      .rst       (rst),
      .irq_in    (irq_in),
      .io_addr   (io_addr),
      .io_wdata  (io_wdata),
      .io_we     (io_we),
      .io_re     (io_re),
      .io_rdata  (io_rdata),
      .cpu_irq   (cpu_irq),
      .cpu_vector(cpu_vector),
      .cpu_ack   (cpu_ack)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [1:0] off, input logic [7:0] d);
      io_addr  = BASE + 16'(off);
      io_wdata = d;
      io_we    = 1'b1;
      tick();
      io_we    = 1'b0;
   endtask

   task automatic rd(input logic [1:0] off, output logic [7:0] d);
      io_addr = BASE + 16'(off);
      io_re   = 1'b1;
      tick();
      io_re   = 1'b0;
      d       = io_rdata;
   endtask

   initial begin
      rst = 1'b1; irq_in = 8'h01; io_addr = 16'h0000; io_wdata = 8'h00;
      io_we = 1'b0; io_re = 1'b0; cpu_ack = 1'b0;
      #1;
      tick(); tick(); tick();
      chk("rst_irq", {7'd0, cpu_irq}, 8'h00);
      chk("rst_vec", {5'd0, cpu_vector}, 8'h00);
      chk("rst_rdata", io_rdata, 8'h00);

      // 1: source high through reset gives no edge
      rst = 1'b0;
      tick();
      wr(2'd0, 8'hFF);
      tick();
      chk("t1_irq", {7'd0, cpu_irq}, 8'h00);
      rd(2'd1, rv); chk("t1_pend", rv, 8'h00);

      // 2: basic request / ack / EOI
      wr(2'd0, 8'h0F);
      irq_in = 8'h05; tick(); irq_in = 8'h01;
      tick();
      chk("t2_irq", {7'd0, cpu_irq}, 8'h01);
      chk("t2_vec", {5'd0, cpu_vector}, 8'h02);
      cpu_ack = 1'b1; tick(); cpu_ack = 1'b0;
      chk("t2_irq_ack", {7'd0, cpu_irq}, 8'h00);
      rd(2'd1, rv); chk("t2_pend", rv, 8'h00);
      rd(2'd2, rv); chk("t2_status", rv, 8'h82);
      wr(2'd3, 8'h00);
      rd(2'd2, rv); chk("t2_status_eoi", rv, 8'h00);

      // 3: pending accumulates during SERVICE, served in priority order
      irq_in = 8'h05; tick(); irq_in = 8'h01;
      tick();
      chk("t3_vec2", {5'd0, cpu_vector}, 8'h02);
      cpu_ack = 1'b1; tick(); cpu_ack = 1'b0;
      irq_in = 8'h09; tick();
      chk("t3_svc_irq_a", {7'd0, cpu_irq}, 8'h00);
      irq_in = 8'h0B; tick();
      tick();
      chk("t3_svc_irq_b", {7'd0, cpu_irq}, 8'h00);
      rd(2'd1, rv); chk("t3_pend", rv, 8'h0A);
      wr(2'd3, 8'h00);
      chk("t3_eoi_irq", {7'd0, cpu_irq}, 8'h00);
      tick();
      chk("t3_irq1", {7'd0, cpu_irq}, 8'h01);
      chk("t3_vec1", {5'd0, cpu_vector}, 8'h01);
      cpu_ack = 1'b1; tick(); cpu_ack = 1'b0;
      wr(2'd3, 8'h00);
      tick();
      chk("t3_irq3", {7'd0, cpu_irq}, 8'h01);
      chk("t3_vec3", {5'd0, cpu_vector}, 8'h03);
      cpu_ack = 1'b1; tick(); cpu_ack = 1'b0;
      wr(2'd3, 8'h00);
      irq_in = 8'h01;
      tick(); tick();
      chk("t3_idle_irq", {7'd0, cpu_irq}, 8'h00);

      // 4: masked capture, then withdrawal by W1C before ack
      wr(2'd0, 8'h00);
      irq_in = 8'h21; tick(); irq_in = 8'h01;
      tick();
      chk("t4_masked_irq", {7'd0, cpu_irq}, 8'h00);
      rd(2'd1, rv); chk("t4_pend", rv, 8'h20);
      wr(2'd0, 8'h20);
      tick();
      chk("t4_irq5", {7'd0, cpu_irq}, 8'h01);
      chk("t4_vec5", {5'd0, cpu_vector}, 8'h05);
      wr(2'd1, 8'h20);
      tick();
      chk("t4_withdraw_irq", {7'd0, cpu_irq}, 8'h00);
      rd(2'd2, rv); chk("t4_status", rv, 8'h00);
      chk("t4_still_idle", {7'd0, cpu_irq}, 8'h00);

      // 5: set wins over same-cycle W1C
      io_addr = BASE + 16'd1; io_wdata = 8'h10; io_we = 1'b1; irq_in = 8'h11;
      tick();
      io_we = 1'b0; irq_in = 8'h01;
      rd(2'd1, rv); chk("t5_pend_set_wins", rv, 8'h10);
      tick();
      chk("t5_rdata_hold", io_rdata, 8'h10);
      wr(2'd1, 8'h10);
      rd(2'd1, rv); chk("t5_pend_w1c", rv, 8'h00);

      // 6: reset while in REQ
      wr(2'd0, 8'hFF);
      rd(2'd0, rv); chk("t6_mask", rv, 8'hFF);
      irq_in = 8'h41; tick(); irq_in = 8'h01;
      tick();
      chk("t6_irq6", {7'd0, cpu_irq}, 8'h01);
      chk("t6_vec6", {5'd0, cpu_vector}, 8'h06);
      rst = 1'b1; tick();
      chk("t6_rst_irq", {7'd0, cpu_irq}, 8'h00);
      chk("t6_rst_vec", {5'd0, cpu_vector}, 8'h00);
      chk("t6_rst_rdata", io_rdata, 8'h00);
      rst = 1'b0;
      rd(2'd0, rv); chk("t6_rst_mask", rv, 8'h00);
      rd(2'd1, rv); chk("t6_rst_pend", rv, 8'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Priority interrupt controller between peripheral interrupt sources and the CPU's interrupt request/acknowledge interface.
- Captures rising edges on up to 8 sources into pending bits and masks them.
- Presents the highest-priority enabled request to the CPU as a request line plus vector.
- Blocks further requests until the handler writes end-of-interrupt (EOI).
- Configured and inspected through four byte registers on the data-memory/IO bus, alongside d_ram.

Parameters:
- NUM_IRQ, 8, number of interrupt sources (1..8); index 0 is highest priority.
- BASE_ADDR, 16'h1000, IO address of register offset 0; registers occupy BASE_ADDR..BASE_ADDR+3.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- irq_in  input  NUM_IRQ  interrupt sources; clk-synchronous levels.
- io_addr  input  16  IO/data bus address.
- io_wdata  input  8  write data from the CPU.
- io_we  input  1  write strobe, one cycle.
- io_re  input  1  read strobe, one cycle.
- io_rdata  output  8  registered read data.
- cpu_irq  output  1  interrupt request to the CPU.
- cpu_vector  output  3  index of the requested interrupt.
- cpu_ack  input  1  one-cycle acknowledge pulse from the CPU.

Behaviour:
- Reset, all synchronous: mask=0, pending=0, state=IDLE, cpu_irq=0, cpu_vector=0, io_rdata=0. During rst, prev_irq loads irq_in, so a source already high when reset is released does not produce an edge.
- Edge capture, every cycle: rise = irq_in & ~prev_irq; prev_irq <= irq_in; pending <= (pending & ~clr) | rise. If set and clear hit the same bit in the same cycle, set wins. Edges are captured in every state, including masked sources.
- Registers, selected by io_addr - BASE_ADDR; writes and reads take effect only when io_addr is in range. Bits at or above NUM_IRQ read 0 and ignore writes.
  - Offset 0, MASK, R/W: 1 enables the source.
  - Offset 1, PENDING: reads return pending; a write of 1 to a bit clears it (W1C).
  - Offset 2, STATUS, read-only: bit7 = in-service flag (state==SERVICE), bits2:0 = in-service vector, other bits 0.
  - Offset 3, EOI, write-only: any write counts as EOI; reads return 0.
- Read latency: io_rdata is valid on the cycle after io_re and holds its value until the next io_re.
- Priority: eligible = pending & mask. The selected vector is the lowest set index of eligible.
- FSM:
  - IDLE: when eligible != 0, latch the vector into cpu_vector, assert cpu_irq next cycle, go to REQ.
  - REQ: cpu_irq=1 and cpu_vector held stable even if higher-priority bits arrive. On cpu_ack: clear pending[cpu_vector], drop cpu_irq next cycle, go to SERVICE. If the latched source's pending bit is cleared by software or its mask bit becomes 0 before ack: drop cpu_irq, go to IDLE; a re-evaluation happens in IDLE on the following cycle.
  - SERVICE: cpu_irq=0; pending keeps accumulating. An EOI write returns to IDLE, and the next request can assert 2 cycles after the EOI write. There is no nesting.
- cpu_ack outside REQ is ignored. An EOI write outside SERVICE is ignored.
- Reset asserted in any state returns to IDLE with all state cleared on the next edge.

Test Plan:
1. Reset with irq_in=8'h01 held high, release, write MASK=8'hFF -> no cpu_irq; PENDING reads 8'h00.
2. MASK=8'h0F, pulse irq_in[2] -> cpu_irq=1, cpu_vector=2 within 2 cycles; cpu_ack -> cpu_irq=0, PENDING=8'h00, STATUS=8'h82; EOI write -> STATUS=8'h00.
3. During SERVICE of vector 2, raise irq_in[3] then irq_in[1] -> no cpu_irq. After EOI -> cpu_vector=1, and after that ack and EOI -> cpu_vector=3.
4. MASK=8'h00, pulse irq_in[5] -> PENDING=8'h20, no cpu_irq; write MASK=8'h20 -> cpu_irq with cpu_vector=5; write PENDING=8'h20 before ack -> cpu_irq drops, state IDLE.
5. Edge on irq_in[4] in the same cycle as a PENDING W1C of 8'h10 -> bit 4 remains set. A read of offset 1 returns 8'h10 one cycle after io_re.
6. Assert rst while in REQ -> next cycle cpu_irq=0, MASK=8'h00, PENDING=8'h00, io_rdata=8'h00.
